tone_sequencer: RTL

Plays a melody stored in an on-chip ROM by stepping through note entries at a fixed beat rate. For each note it generates a square-wave audio sample of programmable half-period and amplitude. It sits between the melody ROM and the Audio_Controller output path, and replaces free-running address and frequency counters with a start/pause/stop-controlled sequencer. It also keeps the DAC FIFO fed through the audio_out_allowed handshake.

---
 rtl/tone_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Melody ROM sequencer: walks note entries at a fixed beat rate and emits a
// square-wave sample per note, under start/pause/stop control.
`timescale 1ns / 1ps

module tone_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int signed   AMPLITUDE   = 10000000,
    parameter int unsigned ROM_LAT     = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_q,
    input  logic              audio_out_allowed,
    output logic [31:0]       sample_out,
    output logic              write_audio_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BeatW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned WaitW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [BeatW-1:0]  BeatLast = BeatW'(BEAT_CYCLES - 1);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] AddrLast = '1;
    localparam logic [31:0]       AmpPos   = 32'(AMPLITUDE);
    localparam logic [31:0]       AmpNeg   = 32'(-AMPLITUDE);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StPaused,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [3:0]        dur_q, dur_d;
    logic [19:0]       hp_q, hp_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [19:0]       tone_q, tone_d;
    logic              phase_q, phase_d;
    logic [31:0]       sample_q, sample_d;
    logic              done_q, done_d;
    logic              end_marker;

    // Next-state, counters and the sample for the next cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        dur_d      = dur_q;
        hp_d       = hp_q;
        beat_d     = beat_q;
        tone_d     = tone_q;
        phase_d    = phase_q;
        sample_d   = '0;
        end_marker = 1'b0;

        if (state_q == StPlay && hp_q != '0) begin
            sample_d = phase_q ? AmpPos : AmpNeg;
        end

        if (stop) begin
            state_d = StIdle;
            addr_d  = '0;
            wait_d  = '0;
            dur_d   = '0;
            hp_d    = '0;
            beat_d  = '0;
            tone_d  = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        addr_d  = '0;
                        wait_d  = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (wait_q == WaitLast) begin
                        wait_d  = '0;
                        state_d = StLoad;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
                StLoad: begin
                    if (rom_q[23:20] == 4'd0) begin
                        end_marker = 1'b1;
                    end else begin
                        dur_d   = rom_q[23:20];
                        hp_d    = rom_q[19:0];
                        beat_d  = '0;
                        tone_d  = '0;
                        phase_d = 1'b0;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    // A start in the same cycle outranks pause and is itself a no-op here.
                    if (pause && !start) begin
                        state_d = StPaused;
                    end else begin
                        if (hp_q != '0) begin
                            if (tone_q == hp_q - 20'd1) begin
                                tone_d  = '0;
                                phase_d = ~phase_q;
                            end else begin
                                tone_d = tone_q + 20'd1;
                            end
                        end else begin
                            phase_d = 1'b0;
                        end
                        if (beat_q == BeatLast) begin
                            beat_d = '0;
                            dur_d  = dur_q - 4'd1;
                            if (dur_q == 4'd1) begin
                                if (addr_q == AddrLast) begin
                                    end_marker = 1'b1;
                                end else begin
                                    addr_d  = addr_q + ADDR_W'(1);
                                    wait_d  = '0;
                                    state_d = StFetch;
                                end
                            end
                        end else begin
                            beat_d = beat_q + BeatW'(1);
                        end
                    end
                end
                StPaused: begin
                    if (start) begin
                        state_d = StPlay;
                    end
                end
                default: state_d = StIdle;
            endcase

            // End of melody: either wrap to the first entry or finish.
            if (end_marker) begin
                if (loop_en) begin
                    addr_d  = '0;
                    wait_d  = '0;
                    state_d = StFetch;
                end else begin
                    state_d = StDone;
                end
            end
        end
    end

    assign done_d = (state_d == StDone) && (state_q != StDone);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wait_q   <= '0;
            dur_q    <= '0;
            hp_q     <= '0;
            beat_q   <= '0;
            tone_q   <= '0;
            phase_q  <= 1'b0;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            dur_q    <= dur_d;
            hp_q     <= hp_d;
            beat_q   <= beat_d;
            tone_q   <= tone_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr        = addr_q;
    assign sample_out      = sample_q;
    assign write_audio_out = audio_out_allowed;
    assign busy            = (state_q == StFetch) || (state_q == StLoad) ||
                             (state_q == StPlay) || (state_q == StPaused);
    assign done            = done_q;

endmodule
